vend_request_arbiter: RTL and testbench

Front-end controller for the vending machine datapath. It arbitrates between a customer request port and an owner request port and issues exactly one datapath command at a time as a mode/code/argument strobe. It then waits for the datapath's completion or error, or for a timeout, and returns a status to the granted requester through a req/ack handshake. It sits between the user-facing input logic and the vending datapath (the block driven by `mode`, `productCode` and the amount/price inputs).

---
 rtl/vend_request_arbiter_if.sv | 18 +
 rtl/vend_request_arbiter.sv | 95 +++++++++
 tb/tb_vend_request_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_request_arbiter_if.sv
// vend_request_arbiter_if: requester ports and datapath command/response bundle.
interface vend_request_arbiter_if;
  logic       custReq, custAck, ownReq, ownAck;
  logic [3:0] custMode, ownMode, custArg, ownArg;
  logic [2:0] custCode, ownCode;
  logic [1:0] custStatus, ownStatus;
  logic [3:0] dpMode, dpArg;
  logic [2:0] dpCode;
  logic       dpStrobe, dpDone, dpError, busy, lastGrant;
  modport slave (
    input  custReq, custMode, custCode, custArg, ownReq, ownMode, ownCode, ownArg, dpDone, dpError,
    output custAck, custStatus, ownAck, ownStatus, dpMode, dpCode, dpArg, dpStrobe, busy, lastGrant
  );
  modport master (
    output custReq, custMode, custCode, custArg, ownReq, ownMode, ownCode, ownArg, dpDone, dpError,
    input  custAck, custStatus, ownAck, ownStatus, dpMode, dpCode, dpArg, dpStrobe, busy, lastGrant
  );
endinterface

// File: rtl/vend_request_arbiter.sv
// vend_request_arbiter: round-robin customer/owner arbiter issuing one datapath command at a time.
module vend_request_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                  mainClock,
  input logic                  resetN,
  vend_request_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t     state_q, state_d;
  logic       sel_q, sel_d, last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] dp_mode_q, dp_mode_d, dp_arg_q, dp_arg_d;
  logic [2:0] dp_code_q, dp_code_d;
  logic [1:0] cust_status_q, cust_status_d, own_status_q, own_status_d, res;
  logic       pick, legal;
  // A tie goes to whichever port was not granted last.
  assign pick  = (bus.custReq && bus.ownReq) ? ~last_q : bus.ownReq;
  assign legal = pick ? (bus.ownMode inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6})
                      : (bus.custMode inside {4'd0, 4'd5, 4'd7});
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    dp_mode_d     = dp_mode_q;
    dp_code_d     = dp_code_q;
    dp_arg_d      = dp_arg_q;
    cust_status_d = cust_status_q;
    own_status_d  = own_status_q;
    res           = 2'b00;
    unique case (state_q)
      IDLE: if (bus.custReq || bus.ownReq) begin
        sel_d   = pick;
        last_d  = pick;
        state_d = legal ? ISSUE : RESP;
        res     = 2'b11;
        if (legal) begin
          dp_mode_d = pick ? bus.ownMode : bus.custMode;
          dp_code_d = pick ? bus.ownCode : bus.custCode;
          dp_arg_d  = pick ? bus.ownArg  : bus.custArg;
        end
      end
      ISSUE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (bus.dpDone || cnt_q == LAST) ? RESP : WAIT;
        res     = bus.dpDone ? {1'b0, bus.dpError} : 2'b10;
      end
      RESP: state_d = IDLE;
    endcase
    // Status is loaded on the edge entering RESP so it is valid alongside the ack.
    if (state_d == RESP) begin
      own_status_d  = sel_d ? res : own_status_q;
      cust_status_d = sel_d ? cust_status_q : res;
    end
  end
  always_ff @(posedge mainClock or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      last_q        <= 1'b1;
      cnt_q         <= 8'd0;
      dp_mode_q     <= 4'd0;
      dp_code_q     <= 3'd0;
      dp_arg_q      <= 4'd0;
      cust_status_q <= 2'b00;
      own_status_q  <= 2'b00;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      dp_mode_q     <= dp_mode_d;
      dp_code_q     <= dp_code_d;
      dp_arg_q      <= dp_arg_d;
      cust_status_q <= cust_status_d;
      own_status_q  <= own_status_d;
    end
  end
  assign bus.dpStrobe   = state_q == ISSUE;
  assign bus.custAck    = state_q == RESP && !sel_q;
  assign bus.ownAck     = state_q == RESP && sel_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.lastGrant  = last_q;
  assign bus.dpMode     = dp_mode_q;
  assign bus.dpCode     = dp_code_q;
  assign bus.dpArg      = dp_arg_q;
  assign bus.custStatus = cust_status_q;
  assign bus.ownStatus  = own_status_q;
endmodule

// File: tb/tb_vend_request_arbiter.sv
// tb_vend_request_arbiter: directed scenarios against vend_request_arbiter with TIMEOUT_CYCLES=4.
module tb_vend_request_arbiter;
  logic mainClock = 1'b0;
  logic resetN = 1'b0;
  int vectors = 0, miscompares = 0;
  int strobes = 0, cust_acks = 0, own_acks = 0;
  vend_request_arbiter_if bus();
  vend_request_arbiter #(.TIMEOUT_CYCLES(4)) dut (.mainClock(mainClock), .resetN(resetN), .bus(bus));
  always #5 mainClock = ~mainClock;
  // Outputs only move on rising edges (or reset), so the falling edge sees each pulse exactly once.
  always @(negedge mainClock) begin
    if (bus.dpStrobe) strobes++;
    if (bus.custAck) cust_acks++;
    if (bus.ownAck) own_acks++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  // Raises one request, drives dpDone/dpError at the given cycle indices, returns cycles until ack.
  task automatic run_cmd(input bit own, input logic [3:0] mode, input logic [2:0] code,
                         input logic [3:0] arg, input int done_at, input int err_at,
                         input bit err, output int n);
    bit got;
    n = 0;
    got = 1'b0;
    if (own) begin
      bus.ownReq = 1'b1; bus.ownMode = mode; bus.ownCode = code; bus.ownArg = arg;
    end else begin
      bus.custReq = 1'b1; bus.custMode = mode; bus.custCode = code; bus.custArg = arg;
    end
    while (!got && n < 30) begin
      @(negedge mainClock);
      n++;
      got = own ? bus.ownAck : bus.custAck;
      bus.dpDone  = !got && n == done_at;
      bus.dpError = !got && ((n == done_at && err) || n == err_at);
    end
    bus.custReq = 1'b0; bus.ownReq = 1'b0; bus.dpDone = 1'b0; bus.dpError = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ack_timeout got no ack after %0d cycles", n);
    end
    @(negedge mainClock);
    vectors++;
    if ({bus.custAck, bus.ownAck, bus.busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL ack_pulse got ack/ack/busy=%b exp=000", {bus.custAck, bus.ownAck, bus.busy});
    end
  endtask
  task automatic test_reset;
    resetN = 1'b0;
    repeat (2) @(negedge mainClock);
    vectors++;
    if ({bus.busy, bus.custAck, bus.ownAck, bus.dpStrobe} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctl got=%b exp=0000", {bus.busy, bus.custAck, bus.ownAck, bus.dpStrobe});
    end
    vectors++;
    if ({bus.custStatus, bus.ownStatus} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_status got=%b exp=0000", {bus.custStatus, bus.ownStatus});
    end
    vectors++;
    if ({bus.dpMode, bus.dpCode, bus.dpArg} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_dp got=%h exp=0", {bus.dpMode, bus.dpCode, bus.dpArg});
    end
    vectors++;
    if (bus.lastGrant !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_last got=%b exp=1", bus.lastGrant);
    end
    resetN = 1'b1;
    @(negedge mainClock);
  endtask
  task automatic test_simultaneous;
    bus.custReq = 1'b1; bus.custMode = 4'd7; bus.custCode = 3'd0; bus.custArg = 4'd10;
    bus.ownReq = 1'b1; bus.ownMode = 4'd4; bus.ownCode = 3'd4; bus.ownArg = 4'd15;
    @(negedge mainClock);
    vectors++;
    if ({bus.dpStrobe, bus.dpMode, bus.dpCode, bus.dpArg, bus.lastGrant} !== {1'b1, 4'd7, 3'd0, 4'd10, 1'b0}) begin
      miscompares++;
      $display("FAIL sim_first got stb/mode/code/arg/last=%b/%0d/%0d/%0d/%b exp=1/7/0/10/0",
               bus.dpStrobe, bus.dpMode, bus.dpCode, bus.dpArg, bus.lastGrant);
    end
    @(negedge mainClock);
    bus.dpDone = 1'b1;
    @(negedge mainClock);
    vectors++;
    if ({bus.custAck, bus.ownAck, bus.custStatus} !== 4'b1000) begin
      miscompares++;
      $display("FAIL sim_cust_ack got cack/oack/cstat=%b/%b/%b exp=1/0/00", bus.custAck, bus.ownAck, bus.custStatus);
    end
    bus.dpDone = 1'b0; bus.custReq = 1'b0;
    @(negedge mainClock);
    vectors++;
    if ({bus.busy, bus.dpStrobe} !== 2'b00) begin
      miscompares++;
      $display("FAIL sim_idle_gap got busy/stb=%b exp=00", {bus.busy, bus.dpStrobe});
    end
    @(negedge mainClock);
    vectors++;
    if ({bus.dpStrobe, bus.dpMode, bus.dpCode, bus.dpArg, bus.lastGrant} !== {1'b1, 4'd4, 3'd4, 4'd15, 1'b1}) begin
      miscompares++;
      $display("FAIL sim_second got stb/mode/code/arg/last=%b/%0d/%0d/%0d/%b exp=1/4/4/15/1",
               bus.dpStrobe, bus.dpMode, bus.dpCode, bus.dpArg, bus.lastGrant);
    end
    @(negedge mainClock);
    bus.dpDone = 1'b1;
    @(negedge mainClock);
    vectors++;
    if ({bus.ownAck, bus.custAck, bus.ownStatus} !== 4'b1000) begin
      miscompares++;
      $display("FAIL sim_own_ack got oack/cack/ostat=%b/%b/%b exp=1/0/00", bus.ownAck, bus.custAck, bus.ownStatus);
    end
    bus.dpDone = 1'b0; bus.ownReq = 1'b0;
    @(negedge mainClock);
  endtask
  task automatic test_buy;
    int n, s0, c0, o0;
    s0 = strobes; c0 = cust_acks; o0 = own_acks;
    run_cmd(1'b0, 4'd0, 3'd0, 4'd1, 3, 0, 1'b0, n);
    vectors++;
    if (n !== 4) begin
      miscompares++;
      $display("FAIL buy_latency got=%0d exp=4", n);
    end
    vectors++;
    if ({bus.custStatus, bus.dpMode, bus.dpCode, bus.dpArg} !== {2'b00, 4'd0, 3'd0, 4'd1}) begin
      miscompares++;
      $display("FAIL buy_cmd got stat/mode/code/arg=%b/%0d/%0d/%0d exp=00/0/0/1",
               bus.custStatus, bus.dpMode, bus.dpCode, bus.dpArg);
    end
    vectors++;
    if ({strobes - s0, cust_acks - c0, own_acks - o0} !== {32'd1, 32'd1, 32'd0}) begin
      miscompares++;
      $display("FAIL buy_counts got strobes/cacks/oacks=%0d/%0d/%0d exp=1/1/0", strobes - s0, cust_acks - c0, own_acks - o0);
    end
  endtask
  task automatic test_illegal;
    int n, s0;
    s0 = strobes;
    run_cmd(1'b1, 4'd0, 3'd1, 4'd1, 0, 0, 1'b0, n);
    vectors++;
    if (n !== 1 || bus.ownStatus !== 2'b11) begin
      miscompares++;
      $display("FAIL illegal_own0 got lat/stat=%0d/%b exp=1/11", n, bus.ownStatus);
    end
    run_cmd(1'b0, 4'd2, 3'd1, 4'd1, 0, 0, 1'b0, n);
    vectors++;
    if (n !== 1 || bus.custStatus !== 2'b11) begin
      miscompares++;
      $display("FAIL illegal_cust2 got lat/stat=%0d/%b exp=1/11", n, bus.custStatus);
    end
    run_cmd(1'b0, 4'd9, 3'd1, 4'd1, 0, 0, 1'b0, n);
    vectors++;
    if (n !== 1 || bus.custStatus !== 2'b11) begin
      miscompares++;
      $display("FAIL illegal_cust9 got lat/stat=%0d/%b exp=1/11", n, bus.custStatus);
    end
    vectors++;
    if (strobes - s0 !== 0 || {bus.dpMode, bus.dpCode, bus.dpArg} !== {4'd0, 3'd0, 4'd1}) begin
      miscompares++;
      $display("FAIL illegal_nostrobe got strobes=%0d dp=%h exp=0 dp=%h", strobes - s0,
               {bus.dpMode, bus.dpCode, bus.dpArg}, {4'd0, 3'd0, 4'd1});
    end
  endtask
  task automatic test_timeout;
    int n, s0;
    s0 = strobes;
    run_cmd(1'b0, 4'd5, 3'd3, 4'd2, 0, 0, 1'b0, n);
    vectors++;
    if (n !== 6 || bus.custStatus !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout got lat/stat=%0d/%b exp=6/10", n, bus.custStatus);
    end
    vectors++;
    if (strobes - s0 !== 1 || bus.dpMode !== 4'd5) begin
      miscompares++;
      $display("FAIL timeout_cmd got strobes/mode=%0d/%0d exp=1/5", strobes - s0, bus.dpMode);
    end
    run_cmd(1'b0, 4'd7, 3'd1, 4'd3, 5, 0, 1'b0, n);
    vectors++;
    if (n !== 6 || bus.custStatus !== 2'b00) begin
      miscompares++;
      $display("FAIL done_wins got lat/stat=%0d/%b exp=6/00", n, bus.custStatus);
    end
  endtask
  task automatic test_error;
    int n;
    run_cmd(1'b1, 4'd2, 3'd0, 4'd10, 4, 2, 1'b1, n);
    vectors++;
    if (n !== 5 || bus.ownStatus !== 2'b01) begin
      miscompares++;
      $display("FAIL error got lat/stat=%0d/%b exp=5/01", n, bus.ownStatus);
    end
    vectors++;
    if (bus.custStatus !== 2'b00) begin
      miscompares++;
      $display("FAIL error_other got cstat=%b exp=00", bus.custStatus);
    end
  endtask
  task automatic test_reset_mid_wait;
    int n, c0, o0;
    c0 = cust_acks; o0 = own_acks;
    bus.custReq = 1'b1; bus.custMode = 4'd0; bus.custCode = 3'd1; bus.custArg = 4'd2;
    repeat (2) @(negedge mainClock);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy got=%b exp=1", bus.busy);
    end
    #1 resetN = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.custAck, bus.ownAck, bus.dpStrobe, bus.custStatus, bus.ownStatus, bus.lastGrant} !== 9'b000000001) begin
      miscompares++;
      $display("FAIL async_reset got=%b exp=000000001",
               {bus.busy, bus.custAck, bus.ownAck, bus.dpStrobe, bus.custStatus, bus.ownStatus, bus.lastGrant});
    end
    vectors++;
    if ({bus.dpMode, bus.dpCode, bus.dpArg} !== 11'd0) begin
      miscompares++;
      $display("FAIL async_reset_dp got=%h exp=0", {bus.dpMode, bus.dpCode, bus.dpArg});
    end
    bus.custReq = 1'b0;
    @(negedge mainClock);
    bus.dpDone = 1'b1;
    @(negedge mainClock);
    resetN = 1'b1;
    @(negedge mainClock);
    bus.dpDone = 1'b0;
    @(negedge mainClock);
    vectors++;
    if (bus.busy !== 1'b0 || cust_acks - c0 !== 0 || own_acks - o0 !== 0) begin
      miscompares++;
      $display("FAIL late_done got busy=%b cacks=%0d oacks=%0d exp=0/0/0", bus.busy, cust_acks - c0, own_acks - o0);
    end
    run_cmd(1'b1, 4'd3, 3'd2, 4'd5, 2, 0, 1'b0, n);
    vectors++;
    if (n !== 3 || bus.ownStatus !== 2'b00 || {bus.dpMode, bus.dpCode, bus.dpArg} !== {4'd3, 3'd2, 4'd5}) begin
      miscompares++;
      $display("FAIL post_reset got lat/stat/dp=%0d/%b/%h exp=3/00/%h", n, bus.ownStatus,
               {bus.dpMode, bus.dpCode, bus.dpArg}, {4'd3, 3'd2, 4'd5});
    end
  endtask
  initial begin
    bus.custReq = 1'b0; bus.custMode = 4'd0; bus.custCode = 3'd0; bus.custArg = 4'd0;
    bus.ownReq = 1'b0; bus.ownMode = 4'd0; bus.ownCode = 3'd0; bus.ownArg = 4'd0;
    bus.dpDone = 1'b0; bus.dpError = 1'b0;
    test_reset;
    test_simultaneous;
    test_buy;
    test_illegal;
    test_timeout;
    test_error;
    test_reset_mid_wait;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
